// File: rtl/nan_pixel_framer.sv
// NanEye pixel framer: tags deserialized pixels with SOF/EOL/EOF and buffers them in a FWFT FIFO.
// Optional build macro PIXEL_FRAMER_TEST_PATTERN_EN replaces pixel data with {row[4:0], col[4:0]}.
module nan_pixel_framer #(
    parameter int C_COLS    = 250,
    parameter int C_ROWS    = 250,
    parameter int C_FIFO_AW = 4,
    parameter int C_CNT_W   = 9
) (
    input  logic                 SCLOCK,
    input  logic                 RESET,
    input  logic                 FRAME_SYNC_START,
    input  logic [9:0]           PIX_DATA,
    input  logic                 PIX_VALID,
    output logic [9:0]           OUT_DATA,
    output logic                 OUT_SOF,
    output logic                 OUT_EOL,
    output logic                 OUT_EOF,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OVERFLOW,
    output logic                 FRAME_ABORT,
    output logic [15:0]          FRAME_CNT,
    output logic [C_FIFO_AW:0]   FIFO_LEVEL
);

    localparam int DEPTH = 1 << C_FIFO_AW;
    localparam logic [C_FIFO_AW:0] FULL_LVL = DEPTH[C_FIFO_AW:0];
    localparam logic [C_CNT_W-1:0] LAST_COL = C_CNT_W'(C_COLS - 1);
    localparam logic [C_CNT_W-1:0] LAST_ROW = C_CNT_W'(C_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t               state_q;
    logic                 fs_q;
    logic [C_CNT_W-1:0]   col_q, row_q, col_d, row_d;
    logic                 ovf_q, abort_q;
    logic [15:0]          cnt_q;

    logic [C_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [C_FIFO_AW:0]   level_q, level_d;
    logic [12:0]          mem_q [DEPTH];

    logic                 fs_rise, push, pop, full, wr_en, drop;
    logic [C_CNT_W-1:0]   col_eff, row_eff;
    logic                 sof, eol, eof;
    logic [9:0]           pix_val;
    logic [12:0]          pix_word, head;

    assign fs_rise = FRAME_SYNC_START & ~fs_q;
    assign push    = PIX_VALID & (state_q == S_ACTIVE);
    assign pop     = OUT_VALID & OUT_READY;
    assign full    = (level_q == FULL_LVL);
    assign wr_en   = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // A frame restart on the same cycle as a pixel makes that pixel the new SOF.
    assign col_eff = fs_rise ? '0 : col_q;
    assign row_eff = fs_rise ? '0 : row_q;
    assign sof     = (row_eff == '0) && (col_eff == '0);
    assign eol     = (col_eff == LAST_COL);
    assign eof     = eol && (row_eff == LAST_ROW);

`ifdef PIXEL_FRAMER_TEST_PATTERN_EN
    assign pix_val = {row_eff[4:0], col_eff[4:0]};
`else
    assign pix_val = PIX_DATA;
`endif

    assign pix_word = {sof, eol, eof, pix_val};

    always_comb begin
        col_d = col_eff;
        row_d = row_eff;
        if (push) begin
            if (eof) begin
                col_d = '0;
                row_d = '0;
            end else if (eol) begin
                col_d = '0;
                row_d = row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
            end
        end
    end

    always_ff @(posedge SCLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            fs_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            fs_q    <= FRAME_SYNC_START;
            col_q   <= col_d;
            row_q   <= row_d;
            abort_q <= 1'b0;
            // A drop in the restart cycle belongs to the new frame, so it wins over the clear.
            if (drop)
                ovf_q <= 1'b1;
            else if (fs_rise)
                ovf_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fs_rise)
                        state_q <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (fs_rise) begin
                        abort_q <= 1'b1;
                    end else if (push && eof) begin
                        state_q <= S_DONE;
                        cnt_q   <= cnt_q + 16'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !wr_en)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge SCLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset; the output mux hides stale entries.
    always_ff @(posedge SCLOCK) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= pix_word;
    end

    assign head      = mem_q[rd_ptr_q];
    assign OUT_VALID = (level_q != '0);
    assign {OUT_SOF, OUT_EOL, OUT_EOF, OUT_DATA} = OUT_VALID ? head : 13'd0;

    assign OVERFLOW    = ovf_q;
    assign FRAME_ABORT = abort_q;
    assign FRAME_CNT   = cnt_q;
    assign FIFO_LEVEL  = level_q;

endmodule

// File: tb/tb_nan_pixel_framer.sv
// Directed bench for nan_pixel_framer on a 4x3 frame with a 4-deep FIFO.
module tb_nan_pixel_framer;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int AW   = 2;

    logic        SCLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        FRAME_SYNC_START = 1'b0;
    logic [9:0]  PIX_DATA = '0;
    logic        PIX_VALID = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [9:0]  OUT_DATA;
    logic        OUT_SOF, OUT_EOL, OUT_EOF, OUT_VALID;
    logic        OVERFLOW, FRAME_ABORT;
    logic [15:0] FRAME_CNT;
    logic [AW:0] FIFO_LEVEL;

    int n_checks = 0;
    int n_errors = 0;
    logic [12:0] got_q[$];

    nan_pixel_framer #(
        .C_COLS(COLS), .C_ROWS(ROWS), .C_FIFO_AW(AW), .C_CNT_W(9)
    ) dut (
        .SCLOCK(SCLOCK), .RESET(RESET), .FRAME_SYNC_START(FRAME_SYNC_START),
        .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
        .OUT_DATA(OUT_DATA), .OUT_SOF(OUT_SOF), .OUT_EOL(OUT_EOL), .OUT_EOF(OUT_EOF),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OVERFLOW(OVERFLOW), .FRAME_ABORT(FRAME_ABORT),
        .FRAME_CNT(FRAME_CNT), .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 SCLOCK = ~SCLOCK;

    // Record every word the consumer takes; inputs only change just after the rising edge.
    always @(negedge SCLOCK)
        if (OUT_VALID && OUT_READY)
            got_q.push_back({OUT_SOF, OUT_EOL, OUT_EOF, OUT_DATA});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge SCLOCK);
        #1;
    endtask

    task automatic push_pix(input int data);
        PIX_DATA  = 10'(data);
        PIX_VALID = 1'b1;
        tick();
        PIX_VALID = 1'b0;
    endtask

    task automatic frame_start();
        FRAME_SYNC_START = 1'b0;
        tick();
        FRAME_SYNC_START = 1'b1;
        tick();
    endtask

    function automatic logic [12:0] exp_word(input int idx, input int data);
        int r;
        int c;
        logic [9:0] d;
        r = idx / COLS;
        c = idx % COLS;
`ifdef PIXEL_FRAMER_TEST_PATTERN_EN
        d = {r[4:0], c[4:0]};
`else
        d = data[9:0];
`endif
        return {idx == 0, c == COLS - 1, idx == COLS * ROWS - 1, d};
    endfunction

    task automatic check_queue(input string tag, input int first_data, input int n);
        check({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_word(i, first_data + i)));
    endtask

    initial begin
        tick(2);
        check("rst_ctrl", 32'({OUT_VALID, OUT_SOF, OUT_EOL, OUT_EOF, OVERFLOW, FRAME_ABORT}), 32'd0);
        check("rst_data", 32'(OUT_DATA), 32'd0);
        check("rst_cnt", 32'(FRAME_CNT), 32'd0);
        check("rst_level", 32'(FIFO_LEVEL), 32'd0);
        RESET = 1'b1;
        tick();

        OUT_READY = 1'b1;
        push_pix(7); push_pix(8); push_pix(9);
        tick();
        check("idle_level", 32'(FIFO_LEVEL), 32'd0);
        check("idle_valid", 32'(OUT_VALID), 32'd0);
        check("idle_popped", 32'(got_q.size()), 32'd0);

        got_q.delete();
        frame_start();
        for (int i = 1; i <= 12; i++)
            push_pix(i);
        tick(3);
        check_queue("nom", 1, 12);
        check("nom_cnt", 32'(FRAME_CNT), 32'd1);
        push_pix(99);
        tick();
        check("nom_back_idle", 32'(FIFO_LEVEL), 32'd0);

        OUT_READY = 1'b0;
        got_q.delete();
        frame_start();
        for (int i = 21; i <= 26; i++)
            push_pix(i);
        check("ovf_level", 32'(FIFO_LEVEL), 32'd4);
        check("ovf_flag", 32'(OVERFLOW), 32'd1);
        check("ovf_head", 32'({OUT_SOF, OUT_EOL, OUT_EOF, OUT_DATA}), 32'(exp_word(0, 21)));
        tick(2);
        check("ovf_hold", 32'({OUT_VALID, OUT_SOF, OUT_EOL, OUT_EOF, OUT_DATA}), 32'({1'b1, exp_word(0, 21)}));
        OUT_READY = 1'b1;
        tick(6);
        check_queue("ovf_drain", 21, 4);
        check("ovf_sticky", 32'(OVERFLOW), 32'd1);
        frame_start();
        check("ovf_clear", 32'(OVERFLOW), 32'd0);
        check("ovf_restart_abort", 32'(FRAME_ABORT), 32'd1);

        got_q.delete();
        OUT_READY = 1'b0;
        for (int i = 31; i <= 34; i++)
            push_pix(i);
        check("pp_full", 32'(FIFO_LEVEL), 32'd4);
        OUT_READY = 1'b1;
        push_pix(35);
        OUT_READY = 1'b0;
        check("pp_level", 32'(FIFO_LEVEL), 32'd4);
        check("pp_no_ovf", 32'(OVERFLOW), 32'd0);
        OUT_READY = 1'b1;
        tick(6);
        check_queue("pp", 31, 5);

        got_q.delete();
        frame_start();
        check("abort_pulse", 32'(FRAME_ABORT), 32'd1);
        check("abort_cnt", 32'(FRAME_CNT), 32'd1);
        tick();
        check("abort_one_cycle", 32'(FRAME_ABORT), 32'd0);
        push_pix(41);
        tick(2);
        check_queue("abort_sof", 41, 1);

        got_q.delete();
        FRAME_SYNC_START = 1'b0;
        tick();
        FRAME_SYNC_START = 1'b1;
        push_pix(51);
        check("sim_abort", 32'(FRAME_ABORT), 32'd1);
        push_pix(52);
        tick(2);
        check_queue("sim", 51, 2);
        check("sim_cnt", 32'(FRAME_CNT), 32'd1);

        OUT_READY = 1'b0;
        push_pix(61); push_pix(62); push_pix(63);
        check("mrst_pre_level", 32'(FIFO_LEVEL), 32'd3);
        RESET = 1'b0;
        FRAME_SYNC_START = 1'b0;
        #1;
        check("mrst_valid", 32'(OUT_VALID), 32'd0);
        check("mrst_level", 32'(FIFO_LEVEL), 32'd0);
        check("mrst_cnt", 32'(FRAME_CNT), 32'd0);
        check("mrst_data", 32'(OUT_DATA), 32'd0);
        tick();
        RESET = 1'b1;
        tick();
        OUT_READY = 1'b1;
        push_pix(71); push_pix(72); push_pix(73);
        tick(2);
        check("mrst_after_level", 32'(FIFO_LEVEL), 32'd0);
        check("mrst_after_valid", 32'(OUT_VALID), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nan_pixel_framer.md
Name: nan_pixel_framer

Overview:
Downstream neighbour of the NanEye RX deserializer. It takes the 10-bit pixel strobes recovered per 12-bit serial word and tags them with frame/line position: start of frame (SOF), end of line (EOL) and end of frame (EOF). Tagged pixels are buffered in a small FIFO and presented on a valid/ready stream to the frame-store / USB packer. It also reports overflow, aborted frames and a frame count.

Parameters:
C_COLS, 250, pixels per line
C_ROWS, 250, lines per frame
C_FIFO_AW, 4, FIFO address width; depth = 2**C_FIFO_AW
C_CNT_W, 9, width of the column and row counters

Ports:
SCLOCK  in  1  pixel-domain clock
RESET  in  1  asynchronous reset, active-low
FRAME_SYNC_START  in  1  level from the sync detector; a rising edge marks a frame start
PIX_DATA  in  10  pixel value, qualified by PIX_VALID
PIX_VALID  in  1  one-cycle strobe per received pixel
OUT_DATA  out  10  pixel at the FIFO head
OUT_SOF  out  1  head word is pixel (row 0, col 0)
OUT_EOL  out  1  head word is the last column of a line
OUT_EOF  out  1  head word is the last pixel of the frame
OUT_VALID  out  1  FIFO not empty
OUT_READY  in  1  consumer accepts the head word
OVERFLOW  out  1  sticky; a pixel was dropped because the FIFO was full
FRAME_ABORT  out  1  one-cycle pulse when a new frame starts before EOF
FRAME_CNT  out  16  count of completed frames; wraps at 0xFFFF->0
FIFO_LEVEL  out  C_FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; all counters = 0; FIFO empty.
  - Outputs at reset: OUT_VALID=0, OUT_DATA=0, OUT_SOF/EOL/EOF=0, OVERFLOW=0, FRAME_ABORT=0, FRAME_CNT=0, FIFO_LEVEL=0.
- Edge detect: FRAME_SYNC_START is registered once. fs_rise = FRAME_SYNC_START & ~fs_q.
- FSM states:
  - IDLE -> ACTIVE on fs_rise.
  - ACTIVE -> DONE on the cycle the EOF pixel is accepted.
  - ACTIVE -> ACTIVE on fs_rise: restart the frame and pulse FRAME_ABORT for 1 cycle.
  - DONE -> IDLE unconditionally after 1 cycle. FRAME_CNT increments on entry to DONE.
- On every fs_rise (any state): col=0, row=0, OVERFLOW cleared. The FIFO is NOT flushed.
- PIX_VALID outside ACTIVE is ignored: no write, counters unchanged.
- Pixel handling in ACTIVE with PIX_VALID=1:
  - Build word {SOF, EOL, EOF, PIX_DATA}:
    - SOF = (row==0 && col==0)
    - EOL = (col==C_COLS-1)
    - EOF = EOL && (row==C_ROWS-1)
  - Counter update: if col==C_COLS-1, then col=0 and row=row+1; otherwise col=col+1.
  - Counters advance whether or not the word is stored, so the frame geometry is preserved through overflow.
- FIFO:
  - Synchronous, first-word-fall-through, depth 2**C_FIFO_AW, 13-bit words.
  - push = PIX_VALID in ACTIVE. pop = OUT_VALID & OUT_READY.
  - push is accepted if not full, or if full and pop occurs in the same cycle.
  - Otherwise the word is dropped and OVERFLOW is set the next cycle.
  - Pointers wrap modulo depth. FIFO_LEVEL = +1 on push only, -1 on pop only, unchanged on both.
  - Latency: a pixel written into an empty FIFO at edge n gives OUT_VALID=1 with that word at edge n+1.
  - OUT_DATA and flags are held stable while OUT_VALID=1 and OUT_READY=0.
  - pop on an empty FIFO cannot occur because OUT_VALID gates it.
- Simultaneous fs_rise and PIX_VALID in ACTIVE: the restart takes priority. The pixel is written as SOF (row 0, col 0) and col becomes 1.
- Reset mid-frame discards the FIFO contents and returns the block to IDLE.

Optional Feature:
PIXEL_FRAMER_TEST_PATTERN_EN
- Defined: stored pixel data is replaced by {row[4:0], col[4:0]}. Timing, flags and handshake are unchanged. Used for link bring-up without a sensor.
- Undefined: PIX_DATA is stored unmodified and no pattern logic is synthesized.

Test Plan:
- Nominal frame, C_COLS=4, C_ROWS=3, OUT_READY=1:
  - Stimulus: fs_rise, then 12 PIX_VALID strobes carrying data 1..12.
  - Response: 12 outputs in order. SOF on data 1 only. EOL on 4, 8, 12. EOF on 12 only. FRAME_CNT=1. FSM is back in IDLE.
- Backpressure/overflow, C_FIFO_AW=2, OUT_READY=0:
  - Stimulus: 6 pixels.
  - Response: FIFO_LEVEL saturates at 4, OVERFLOW=1, and the first 4 words drain intact once OUT_READY=1.
  - A following fs_rise clears OVERFLOW.
- Full FIFO with pop and push in the same cycle: both occur, FIFO_LEVEL stays 4, and no OVERFLOW is raised.
- Abort: fs_rise after 5 pixels of a frame -> FRAME_ABORT pulses for 1 cycle. The next pixel carries SOF, and FRAME_CNT does not increment.
- Pixels outside a frame: PIX_VALID strobes in IDLE -> no writes, FIFO_LEVEL=0.
- Mid-operation reset:
  - Stimulus: assert RESET with 3 words buffered.
  - Response: OUT_VALID=0, FIFO_LEVEL=0, FRAME_CNT=0 immediately. After release, no output appears until a new fs_rise.
